program_feeder: RTL and testbench

PROGRAM_FEEDER -- requirements
Module: program_feeder

---
 rtl/feeder_pkg.sv | 14 +
 rtl/program_feeder_if.sv | 13 +
 rtl/program_buffer.sv | 27 ++
 rtl/program_feeder.sv | 105 ++++++++++
 tb/tb_program_feeder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared widths and run-state encoding for the program feeder
package feeder_pkg;

    localparam int INSTR_W = 12;
    localparam int DATA_W  = 8;
    localparam int OP_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/program_feeder_if.sv
// rtl/program_feeder_if.sv - program-load channel between host and program feeder
interface program_feeder_if;
    import feeder_pkg::*;

    logic               LoadValid;
    logic [INSTR_W-1:0] LoadWord;
    logic               LoadReady;
    logic               ProgClear;

    modport master (output LoadValid, output LoadWord, output ProgClear, input LoadReady);
    modport slave  (input LoadValid, input LoadWord, input ProgClear, output LoadReady);

endinterface

// File: rtl/program_buffer.sv
// rtl/program_buffer.sv - program word storage, registered write, combinational read
module program_buffer
    import feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    // Contents are intentionally not reset; Count in the feeder qualifies validity.
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_feeder.sv
// rtl/program_feeder.sv - loads a short program and replays it to the CPU In bus (optional PROGRAM_FEEDER_STEP_EN)
module program_feeder
    import feeder_pkg::*;
#(
    parameter int                 DEPTH     = 8,
    parameter logic [INSTR_W-1:0] IDLE_WORD = 12'h000
) (
    input  logic                       Clk,
    input  logic                       Reset,
    program_feeder_if.slave            load,
    input  logic                       Start,
    input  logic [DATA_W-1:0]          Result,
`ifdef PROGRAM_FEEDER_STEP_EN
    input  logic                       Step,
`endif
    output logic [INSTR_W-1:0]         CpuIn,
    output logic                       Busy,
    output logic                       Done,
    output logic [DATA_W-1:0]          Captured,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    feeder_state_t      state;
    logic [CW-1:0]      index;
    logic [INSTR_W-1:0] rd_word;
    logic               load_fire;
    logic               issue;

    assign load.LoadReady = (state == IDLE) && (Count < DEPTH_C) && !load.ProgClear;
    assign load_fire      = load.LoadValid && load.LoadReady;

`ifdef PROGRAM_FEEDER_STEP_EN
    assign issue = (state == RUN) && Step;
`else
    assign issue = (state == RUN);
`endif

    // CpuIn follows the issue qualifier in the same cycle so a Step stall shows IDLE_WORD.
    assign CpuIn = issue ? rd_word : IDLE_WORD;

    program_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk   (Clk),
        .we    (load_fire),
        .waddr (Count[AW-1:0]),
        .wdata (load.LoadWord),
        .raddr (index[AW-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Count    <= '0;
            index    <= '0;
            Captured <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load.ProgClear) begin
                        Count <= '0;
                    end else begin
                        if (load_fire) begin
                            Count <= Count + 1'b1;
                        end
                        if (Start && (Count != '0)) begin
                            state <= RUN;
                            index <= '0;
                            Busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (index == Count - 1'b1) begin
                            state <= DRAIN;
                            Done  <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    Captured <= Result;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_feeder.sv
// tb/tb_program_feeder.sv - scoreboard bench for program_feeder (optional PROGRAM_FEEDER_STEP_EN)
module tb_program_feeder;
    import feeder_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [11:0] IDLE_WORD = 12'h000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    result;
    logic          step;
    logic [11:0]   cpu_in;
    logic          busy;
    logic          done;
    logic [7:0]    captured;
    logic [CW-1:0] count;

    program_feeder_if load_bus ();

    program_feeder #(
        .DEPTH     (DEPTH),
        .IDLE_WORD (IDLE_WORD)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .load     (load_bus),
        .Start    (start),
        .Result   (result),
`ifdef PROGRAM_FEEDER_STEP_EN
        .Step     (step),
`endif
        .CpuIn    (cpu_in),
        .Busy     (busy),
        .Done     (done),
        .Captured (captured),
        .Count    (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] model[DEPTH];
    int model_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every RUN cycle either issues the next scoreboard word or, when stalled, IDLE_WORD.
    always @(negedge clk) begin
        if (!rst && busy && !done) begin
            if (step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got %0h expected no issue", cpu_in);
                end else begin
                    check("cpu_in", cpu_in, exp_q.pop_front());
                end
            end else begin
                check("cpu_in_stalled", cpu_in, IDLE_WORD);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] w);
        load_bus.LoadValid = 1'b1;
        load_bus.LoadWord  = w;
        @(negedge clk);
        check("load_ready", load_bus.LoadReady, model_n < DEPTH);
        if (model_n < DEPTH) begin
            model[model_n] = w;
            model_n++;
        end
        tick();
        load_bus.LoadValid = 1'b0;
    endtask

    task automatic prog_clear();
        load_bus.ProgClear = 1'b1;
        tick();
        load_bus.ProgClear = 1'b0;
        model_n = 0;
    endtask

    task automatic run_program(input logic [7:0] res, input bit hold_start, input bit step_mode);
        int n;
        int exp_done;
        int done_cnt;
        int done_cyc;
        n = model_n;
        exp_done = step_mode ? 3 * n : n;
        done_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < n; i++) exp_q.push_back(model[i]);
        result = ~res;
        start = 1'b1;
        for (int c = 0; c < exp_done + 6; c++) begin
            tick();
            if (!hold_start || c >= n - 1) start = 1'b0;
            step = step_mode ? (c % 3 == 2) : 1'b1;
            result = (c == exp_done) ? res : ~res;
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                check("cpu_in_at_done", cpu_in, IDLE_WORD);
            end
        end
        tick();
        step = 1'b1;
        check("done_count", done_cnt, 1);
        check("run_latency", done_cyc, exp_done);
        check("captured", captured, res);
        check("busy_after_run", busy, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        result = 8'h00;
        step = 1'b1;
        load_bus.LoadValid = 1'b0;
        load_bus.LoadWord = 12'h000;
        load_bus.ProgClear = 1'b0;
        tick();
        check("reset_count", count, 0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_cpu_in", cpu_in, IDLE_WORD);
        check("reset_captured", captured, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("idle_load_ready", load_bus.LoadReady, 1'b1);

        // Basic three-word program, then replay of the same program.
        load_word(12'h1AA);
        load_word(12'h2BB);
        load_word(12'h355);
        check("count_after_load3", count, 3);
        run_program(8'h5C, 1'b0, 1'b0);
        run_program(8'hA7, 1'b0, 1'b0);
        check("count_kept_after_run", count, 3);

        // ProgClear wins over a simultaneous write.
        load_bus.ProgClear = 1'b1;
        load_bus.LoadValid = 1'b1;
        load_bus.LoadWord = 12'h777;
        @(negedge clk);
        check("ready_during_clear", load_bus.LoadReady, 1'b0);
        tick();
        load_bus.ProgClear = 1'b0;
        load_bus.LoadValid = 1'b0;
        model_n = 0;
        check("count_after_clear", count, 0);

        // Start with an empty program does nothing.
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | busy | done;
        end
        tick();
        check("empty_start_ignored", seen, 1'b0);

        // Fill past capacity, then run with Start held during RUN.
        for (int i = 0; i < 9; i++) load_word(12'h101 + 12'(i) * 12'h111);
        check("count_full", count, DEPTH);
        run_program(8'h3E, 1'b1, 1'b0);

        // Reset mid-run after the second word.
        prog_clear();
        load_word(12'hC01);
        load_word(12'hC02);
        load_word(12'hC03);
        for (int i = 0; i < model_n; i++) exp_q.push_back(model[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("words_before_reset", exp_q.size(), 1);
        check("abort_cpu_in", cpu_in, IDLE_WORD);
        check("abort_count", count, 0);
        check("abort_captured", captured, 8'h00);
        check("abort_busy", busy, 1'b0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | done;
        end
        tick();
        check("abort_no_done", seen, 1'b0);
        model_n = 0;

`ifdef PROGRAM_FEEDER_STEP_EN
        load_word(12'h0A1);
        load_word(12'h0B2);
        run_program(8'h99, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
